// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W = $clog2(MAX_LATENCY + 1);
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter that stops at zero and flags it
// ports: clk_i/rst_ni clock and async active-low reset; load_i/load_val_i load;
//        dec_i decrement enable; zero_o count is zero
module wait_counter
  import mem_arb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  assign cnt_d = load_i ? load_val_i : (dec_i && !zero_o) ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
// ports: clk_i/rst_ni clock and async active-low reset; if_* fetch requester;
//        d_* data requester; mem_* memory port; busy_o/owner_o current grant
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_done_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);
  state_e state_q, state_d;
  logic owner_q, owner_d, fair_q, fair_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic grant, grant_data, cnt_zero, last;
  assign grant = state_q == IDLE && (if_req_i || d_req_i);
  // the fair flag hands the next contested grant to fetch after data won one
  assign grant_data = d_req_i && !(fair_q && if_req_i);
  assign last = state_q == ACCESS && cnt_zero;
  wait_counter u_cnt (
    .clk_i,
    .rst_ni,
    .load_i    (grant),
    .load_val_i(CNT_W'(MEM_LATENCY - 1)),
    .dec_i     (state_q == ACCESS),
    .zero_o    (cnt_zero)
  );
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    fair_d     = fair_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (grant) begin
      state_d = ACCESS;
      owner_d = grant_data ? OWNER_DATA : OWNER_FETCH;
      fair_d  = grant_data && if_req_i;
      we_d    = grant_data && d_we_i;
      addr_d  = grant_data ? d_addr_i : if_addr_i;
      wdata_d = grant_data ? d_wdata_i : '0;
    end
    if (last) begin
      state_d    = RESP;
      if_rdata_d = (!we_q && owner_q == OWNER_FETCH) ? mem_rdata_i : if_rdata_q;
      d_rdata_d  = (!we_q && owner_q == OWNER_DATA) ? mem_rdata_i : d_rdata_q;
    end
    if (state_q == RESP) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_FETCH;
      fair_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      fair_q     <= fair_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  assign mem_en_o    = state_q == ACCESS;
  assign mem_we_o    = last && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_done_o   = state_q == RESP && owner_q == OWNER_FETCH;
  assign d_done_o    = state_q == RESP && owner_q == OWNER_DATA;
  assign busy_o      = state_q != IDLE;
  assign owner_o     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the memory port arbiter
module tb_mem_port_arbiter;
  localparam int L = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_done, d_done, mem_en, mem_we, busy, owner;
  typedef struct {logic own; logic [31:0] ifr; logic [31:0] dr;} done_t;
  typedef struct {logic [31:0] a; logic [31:0] w;} wr_t;
  done_t dq[$];
  wr_t wq[$];
  int cmp_n = 0, err_n = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_done_o(if_done),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_done_o(d_done),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .busy_o(busy), .owner_o(owner)
  );
  always_comb
    case (mem_addr)
      32'h0040: mem_rdata = 32'h2008000A;
      32'h0080: mem_rdata = 32'h0080FF7F;
      32'h2000: mem_rdata = 32'h2000DFFF;
      32'h3004: mem_rdata = 32'h3004CFFB;
      default:  mem_rdata = 32'hDEADDEAD;
    endcase
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    done_t e;
    wr_t w;
    if (if_done || d_done) begin
      if (dq.size() == 0) begin
        cmp_n++;
        err_n++;
        $display("FAIL unexpected_done: got if=%0b d=%0b expected none", if_done, d_done);
      end else begin
        e = dq.pop_front();
        chk("done_port", {62'b0, if_done, d_done}, e.own ? 64'd1 : 64'd2);
        chk("if_rdata", {32'b0, if_rdata}, {32'b0, e.ifr});
        chk("d_rdata", {32'b0, d_rdata}, {32'b0, e.dr});
      end
    end
    if (mem_we) begin
      if (wq.size() == 0) begin
        cmp_n++;
        err_n++;
        $display("FAIL unexpected_write: got addr 0x%0h expected no write", mem_addr);
      end else begin
        w = wq.pop_front();
        chk("write", {mem_addr, mem_wdata}, {w.a, w.w});
      end
    end
  end
  task automatic track(input logic own, input logic we, input logic wd);
    @(negedge clk);
    chk("idle_c0", {63'b0, busy}, 64'd0);
    if (wd) begin
      @(posedge clk);
      #1 d_req = 1'b0;
    end
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      chk("access", {60'b0, mem_en, busy, owner, mem_we}, {60'b0, 1'b1, 1'b1, own, (we && k == L)});
    end
    @(negedge clk);
    chk("resp", {60'b0, mem_en, busy, if_done, d_done}, {60'b0, 1'b0, 1'b1, !own, own});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b0; d_we = 1'b1; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {58'b0, if_done, d_done, mem_en, mem_we, busy, owner}, 64'd0);
    chk("reset_bus", {mem_addr, mem_wdata}, 64'd0);
    chk("reset_rdata", {if_rdata, d_rdata}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dq.push_back('{1'b0, 32'h2008000A, 32'h0});
    track(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3004;
    dq.push_back('{1'b1, 32'h2008000A, 32'h3004CFFB});
    track(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF;
    wq.push_back('{32'h1000, 32'hDEADBEEF});
    dq.push_back('{1'b1, 32'h2008000A, 32'h3004CFFB});
    track(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1 d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0;
    dq.push_back('{1'b1, 32'h2008000A, 32'h2000DFFF});
    track(1'b1, 1'b0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("no_regrant", {62'b0, busy, mem_en}, 64'd0);
    end
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_addr = 32'h3004;
    dq.push_back('{1'b1, 32'h2008000A, 32'h3004CFFB});
    dq.push_back('{1'b0, 32'h0080FF7F, 32'h3004CFFB});
    dq.push_back('{1'b1, 32'h0080FF7F, 32'h3004CFFB});
    dq.push_back('{1'b0, 32'h0080FF7F, 32'h3004CFFB});
    for (int i = 0; i < 4; i++) track(i % 2 == 0, 1'b0, 1'b0);
    @(posedge clk);
    #1 if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1004; d_wdata = 32'h12345678;
    @(negedge clk);
    chk("rst_c0", {63'b0, busy}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 chk("we_before_rst", {62'b0, mem_we, mem_en}, 64'd3);
    rst_n = 1'b0; d_req = 1'b0;
    #1 chk("rst_drop", {59'b0, mem_we, mem_en, busy, if_done, d_done}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", {62'b0, busy, mem_en}, 64'd0);
    end
    chk("post_rst_rdata", {if_rdata, d_rdata}, 64'd0);
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3004;
    dq.push_back('{1'b1, 32'h0, 32'h3004CFFB});
    track(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    chk("write_queue_empty", 64'(wq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port of the multicycle CPU between instruction fetch and data load/store, so one memory instance serves both. Sits between the control FSM and the memory. It grants one requester at a time, holds address/data stable for a fixed number of wait cycles, returns read data in per-requester registers, and signals completion with a one-cycle done pulse.

## Interface
- MEM_LATENCY, 2, memory access cycles per transaction (legal range 1..15)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- if_req  in  1  fetch request (level, held until if_done)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  last fetched word
- if_done  out  1  one-cycle fetch-complete pulse
- d_req  in  1  data request (level, held until d_done)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  last loaded word
- d_done  out  1  one-cycle data-complete pulse
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in final ACCESS cycle
- busy  out  1  state != IDLE
- owner  out  1  0 = fetch, 1 = data; meaningful while busy

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req, arbitrate, latch owner, address, we, wdata; load wait counter with MEM_LATENCY-1; go ACCESS. Else stay.
- Arbitration: data wins, unless fair flag set, then fetch wins. Flag sets when data is granted while if_req is high; clears when fetch is granted. Under continuous contention grants alternate D, F, D, F.
- ACCESS: mem_en=1, mem_addr/mem_wdata from latched values. Counter decrements each cycle. At counter==0: mem_we=1 only if latched write (exactly one strobe cycle); for reads, capture mem_rdata into owner's rdata register; go RESP.
- RESP: pulse owner's done; go IDLE. Writes never modify d_rdata.
- Requester drops req at the edge ending RESP. If req is still high in the next IDLE cycle, it is treated as a new request.
- Requester withdrawing req mid-access: transaction completes and done still pulses. Input changes after grant are ignored.
- Fetch with d_we high is irrelevant: the fetch path never writes.

## Timing
- Reset (async, immediate): state IDLE, fair flag 0, counter 0; all outputs 0, including mem_we, mem_en, done pulses, rdata registers, and owner.
- Reset mid-ACCESS: mem_we/mem_en drop immediately; no done is issued. The transaction is lost.
- Latency: req high in IDLE cycle 0 gives ACCESS cycles 1..MEM_LATENCY, RESP cycle MEM_LATENCY+1 (done=1), and IDLE at MEM_LATENCY+2.
- Throughput: one transaction per MEM_LATENCY+2 cycles maximum.
- rdata is valid from the RESP cycle and holds until the next read completes for the same port.
- Simultaneous if_req and d_req in IDLE follow the arbitration rule above. A request arriving during ACCESS/RESP waits.
- Counter is 4 bits and never wraps: it loads at grant and stops at 0.

## Structure
- Shared package mem_arb_pkg:
  - state enum (IDLE, ACCESS, RESP)
  - OWNER_FETCH=0, OWNER_DATA=1
  - MAX_LATENCY=15
- One sub-module, wait_counter: loadable 4-bit down-counter with a zero flag.
- Remaining logic (FSM, arbitration flag, latches, rdata registers) lives in the top module.

## Test plan
- Reset: hold reset=0 with if_req=1 → all outputs 0. Release → grant fetch next edge, owner=0.
- Fetch, MEM_LATENCY=2, if_addr=0x0040, mem_rdata=0x2008000A → mem_en in cycles 1–2, if_done in cycle 3, if_rdata=0x2008000A, mem_we never high.
- Store: d_we=1, d_addr=0x1000, d_wdata=0xDEADBEEF → mem_we high exactly in cycle 2 with those values, then d_done. d_rdata unchanged.
- Contention: if_req and d_req held high for 4 transactions → owner sequence 1,0,1,0. Each done fires once per grant.
- Withdrawal: drop d_req in cycle 1 → access completes, d_done pulses in cycle 3, and there is no regrant.
- Async reset asserted mid-ACCESS of a store → mem_we=0 immediately, no done, state IDLE after release.
